pmod_da4_dac_spi_ctrl: RTL and testbench

Parametrised SPI master for the PMOD DA4 (AD56x8-family, 8-channel DAC). It is the successor to the single-channel fixed-word writer.
- Adds per-channel addressing, broadcast, a selectable update command and a configurable data width.
- Adds an automatic internal-reference setup frame after reset, a valid/ready request handshake and a programmable SCLK rate.
- Sits between user logic and the PMOD header pins cs, sclk and mosi.

---
 rtl/pmod_da4_dac_spi_ctrl_if.sv | 23 ++
 rtl/pmod_da4_dac_spi_ctrl.sv | 155 +++++++++++++++
 tb/tb_pmod_da4_dac_spi_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/pmod_da4_dac_spi_ctrl_if.sv
// Request/response side of the PMOD DA4 controller: user logic is the master,
// the SPI controller is the slave.
interface pmod_da4_dac_spi_ctrl_if #(
    parameter int DATA_W = 12
);
    logic              st_wrt;
    logic              ready;
    logic [2:0]        ch_sel;
    logic              all_ch;
    logic [1:0]        mode;
    logic [DATA_W-1:0] data_in;
    logic              done;

    modport master (
        output st_wrt, ch_sel, all_ch, mode, data_in,
        input  ready, done
    );

    modport slave (
        input  st_wrt, ch_sel, all_ch, mode, data_in,
        output ready, done
    );
endinterface

// File: rtl/pmod_da4_dac_spi_ctrl.sv
// SPI master for the PMOD DA4 (AD56x8): 32-bit write frames with addressing,
// broadcast, update command select and an optional internal-reference init frame.
module pmod_da4_dac_spi_ctrl #(
    parameter int CLK_DIV  = 5,
    parameter int DATA_W   = 12,
    parameter int NUM_CH   = 8,
    parameter int INIT_REF = 1,
    parameter int CS_GAP   = 2
) (
    input  logic                     clk100mhz,
    input  logic                     rst_n,
    pmod_da4_dac_spi_ctrl_if.slave   req,
    output logic                     cs,
    output logic                     sclk,
    output logic                     mosi
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [31:0] INIT_FRAME = 32'h0800_0001;

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_SHIFT, ST_GAP} state_t;

    state_t             state_reg, state_next;
    logic [31:0]        shift_reg, shift_next;
    logic [DIV_W-1:0]   div_reg, div_next;
    logic [5:0]         edge_reg, edge_next;
    logic [GAP_W-1:0]   gap_reg, gap_next;
    logic               cs_reg, cs_next;
    logic               sclk_reg, sclk_next;
    logic               mosi_reg, mosi_next;
    logic               done_reg, done_next;
    logic               init_reg, init_next;

    logic [3:0]         cmd;
    logic [3:0]         addr;
    logic [31:0]        frame;
    logic               ch_bad;

    always_ff @(posedge clk100mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_INIT;
            shift_reg <= '0;
            div_reg   <= '0;
            edge_reg  <= '0;
            gap_reg   <= '0;
            cs_reg    <= 1'b1;
            sclk_reg  <= 1'b1;
            mosi_reg  <= 1'b0;
            done_reg  <= 1'b0;
            init_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            shift_reg <= shift_next;
            div_reg   <= div_next;
            edge_reg  <= edge_next;
            gap_reg   <= gap_next;
            cs_reg    <= cs_next;
            sclk_reg  <= sclk_next;
            mosi_reg  <= mosi_next;
            done_reg  <= done_next;
            init_reg  <= init_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        shift_next = shift_reg;
        div_next   = div_reg;
        edge_next  = edge_reg;
        gap_next   = gap_reg;
        cs_next    = cs_reg;
        sclk_next  = sclk_reg;
        mosi_next  = mosi_reg;
        done_next  = 1'b0;
        init_next  = init_reg;

        case (req.mode)
            2'b00:   cmd = 4'b0000;
            2'b10:   cmd = 4'b0010;
            default: cmd = 4'b0011;
        endcase
        addr   = req.all_ch ? 4'hF : {1'b0, req.ch_sel};
        frame  = {4'b0000, cmd, addr, req.data_in, {(20-DATA_W){1'b0}}};
        ch_bad = !req.all_ch && ({1'b0, req.ch_sel} >= 4'(NUM_CH));

        case (state_reg)
            ST_INIT: begin
                div_next  = '0;
                edge_next = '0;
                if (INIT_REF != 0) begin
                    shift_next = {INIT_FRAME[30:0], 1'b0};
                    mosi_next  = INIT_FRAME[31];
                    cs_next    = 1'b0;
                    init_next  = 1'b1;
                    state_next = ST_SHIFT;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (req.st_wrt) begin
                    init_next = 1'b0;
                    div_next  = '0;
                    edge_next = '0;
                    gap_next  = '0;
                    // Out-of-range channel: keep cs high, just pace the handshake
                    if (ch_bad) begin
                        state_next = ST_GAP;
                    end else begin
                        shift_next = {frame[30:0], 1'b0};
                        mosi_next  = frame[31];
                        cs_next    = 1'b0;
                        state_next = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                if (div_reg == DIV_W'(CLK_DIV - 1)) begin
                    div_next  = '0;
                    sclk_next = ~sclk_reg;
                    edge_next = edge_reg + 6'd1;
                    // Data advances on the rising edge so it is stable at each fall
                    if (!sclk_reg) begin
                        mosi_next  = shift_reg[31];
                        shift_next = {shift_reg[30:0], 1'b0};
                        if (edge_reg == 6'd63) begin
                            cs_next    = 1'b1;
                            mosi_next  = 1'b0;
                            gap_next   = '0;
                            state_next = ST_GAP;
                        end
                    end
                end else begin
                    div_next = div_reg + 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_reg == GAP_W'(CS_GAP - 1)) begin
                    done_next  = !init_reg;
                    init_next  = 1'b0;
                    state_next = ST_IDLE;
                end else begin
                    gap_next = gap_reg + 1'b1;
                end
            end
            default: state_next = ST_INIT;
        endcase
    end

    assign req.ready = (state_reg == ST_IDLE);
    assign req.done  = done_reg;
    assign cs        = cs_reg;
    assign sclk      = sclk_reg;
    assign mosi      = mosi_reg;
endmodule

// File: tb/tb_pmod_da4_dac_spi_ctrl.sv
// Self-checking bench: decodes SPI frames from the pins and compares them and
// their timing against a frame/timing model built from the field rules.
module tb_pmod_da4_dac_spi_ctrl;
    logic clk;
    logic rst_n;
    logic cs0, sclk0, mosi0;
    logic cs1, sclk1, mosi1;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   sel      = 1'b0;

    logic m_cs, m_sclk, m_mosi, m_ready, m_done;

    pmod_da4_dac_spi_ctrl_if #(.DATA_W(12)) if0();
    pmod_da4_dac_spi_ctrl_if #(.DATA_W(16)) if1();

    pmod_da4_dac_spi_ctrl u_dut (
        .clk100mhz(clk), .rst_n(rst_n), .req(if0),
        .cs(cs0), .sclk(sclk0), .mosi(mosi0)
    );

    pmod_da4_dac_spi_ctrl #(.CLK_DIV(2), .DATA_W(16), .NUM_CH(6)) u_dut16 (
        .clk100mhz(clk), .rst_n(rst_n), .req(if1),
        .cs(cs1), .sclk(sclk1), .mosi(mosi1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        m_cs = cs0; m_sclk = sclk0; m_mosi = mosi0; m_ready = if0.ready; m_done = if0.done;
        if (sel) begin
            m_cs = cs1; m_sclk = sclk1; m_mosi = mosi1; m_ready = if1.ready; m_done = if1.done;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_frame(int dw, int ch, bit all, int mode, int data);
        int cmd;
        int addr;
        cmd  = (mode == 0) ? 0 : (mode == 2) ? 2 : 3;
        addr = all ? 15 : ch;
        return 32'(cmd * (1 << 24) + addr * (1 << 20) + data * (1 << (20 - dw)));
    endfunction

    task automatic wait_ready();
        for (int i = 0; i < 2000; i++) begin
            if (m_ready) break;
            @(negedge clk);
        end
        chk("wait_ready", 32'(m_ready), 32'd1);
    endtask

    // Called at the falling clock edge inside the accept cycle (cycle 0)
    task automatic start_req(input int ch, input bit all, input int mode, input int data);
        chk("ready_at_accept", 32'(m_ready), 32'd1);
        if (!sel) begin
            if0.ch_sel = 3'(ch); if0.all_ch = all; if0.mode = 2'(mode);
            if0.data_in = 12'(data); if0.st_wrt = 1'b1;
        end else begin
            if1.ch_sel = 3'(ch); if1.all_ch = all; if1.mode = 2'(mode);
            if1.data_in = 16'(data); if1.st_wrt = 1'b1;
        end
    endtask

    task automatic observe(input int d, input int g, input bit hold,
                           output logic [31:0] frame, output int nfall,
                           output int fall0, output int fall1, output int cs_fall,
                           output int cs_rise, output int rdy_cyc, output int done_cnt,
                           output int bad_tog);
        logic cs_p, sclk_p;
        frame = '0; nfall = 0; fall0 = -1; fall1 = -1; cs_fall = -1; cs_rise = -1;
        rdy_cyc = -1; done_cnt = 0; bad_tog = 0;
        cs_p = m_cs; sclk_p = m_sclk;
        for (int c = 1; c <= 64 * d + g + 20; c++) begin
            @(negedge clk);
            // Scramble request fields after accept: the frame in flight must not change
            if (c == 1 && !hold) begin
                if (!sel) begin
                    if0.st_wrt = 1'b0; if0.data_in = 12'($urandom); if0.ch_sel = 3'($urandom);
                    if0.all_ch = 1'($urandom); if0.mode = 2'($urandom);
                end else begin
                    if1.st_wrt = 1'b0; if1.data_in = 16'($urandom); if1.ch_sel = 3'($urandom);
                    if1.all_ch = 1'($urandom); if1.mode = 2'($urandom);
                end
            end
            if (m_done) done_cnt++;
            if (cs_p && !m_cs && cs_fall < 0) cs_fall = c;
            if (!cs_p && m_cs && cs_rise < 0) cs_rise = c;
            if (sclk_p && !m_sclk) begin
                if (nfall < 32) frame = {frame[30:0], m_mosi};
                if (nfall == 0) fall0 = c;
                if (nfall == 1) fall1 = c;
                nfall++;
            end
            if (cs_p && m_cs && (sclk_p != m_sclk)) bad_tog++;
            cs_p = m_cs; sclk_p = m_sclk;
            if (m_ready) begin
                rdy_cyc = c;
                break;
            end
        end
    endtask

    task automatic do_frame(input string tag, input int d, input int g, input bit hold,
                            input logic [31:0] exp, input bit is_init,
                            output int rise_o, output int rdy_o, output int fall_o);
        logic [31:0] fr;
        int nf, f0, f1, cf, cr, rc, dc, bt;
        observe(d, g, hold, fr, nf, f0, f1, cf, cr, rc, dc, bt);
        $display("%s: frame=%08h expect=%08h falls=%0d cs_low@%0d cs_high@%0d ready@%0d dones=%0d",
                 tag, fr, exp, nf, cf, cr, rc, dc);
        chk({tag, "_frame"}, fr, exp);
        chk({tag, "_falls"}, 32'(nf), 32'd32);
        chk({tag, "_cs_fall"}, 32'(cf), 32'd1);
        chk({tag, "_first_fall"}, 32'(f0), 32'(1 + d));
        chk({tag, "_sclk_period"}, 32'(f1 - f0), 32'(2 * d));
        chk({tag, "_cs_rise"}, 32'(cr), 32'(1 + 64 * d));
        chk({tag, "_ready_rise"}, 32'(rc), 32'(1 + 64 * d + g));
        chk({tag, "_done_count"}, 32'(dc), is_init ? 32'd0 : 32'd1);
        chk({tag, "_done_at_ready"}, 32'(m_done), is_init ? 32'd0 : 32'd1);
        chk({tag, "_sclk_idle"}, 32'(bt), 32'd0);
        rise_o = cr; rdy_o = rc; fall_o = cf;
    endtask

    initial begin
        int r1, y1, f1, r2, y2, f2, r3, y3, f3, nf;
        logic sp;
        int ch, all, md, dat;
        logic [31:0] fr;
        int xf0, xf1, xcf, xcr, xrc, xdc, xbt;

        rst_n = 1'b0;
        if0.st_wrt = 1'b0; if0.ch_sel = '0; if0.all_ch = 1'b0; if0.mode = '0; if0.data_in = '0;
        if1.st_wrt = 1'b0; if1.ch_sel = '0; if1.all_ch = 1'b0; if1.mode = '0; if1.data_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_cs", 32'(cs0), 32'd1);
        chk("rst_sclk", 32'(sclk0), 32'd1);
        chk("rst_mosi", 32'(mosi0), 32'd0);
        chk("rst_done", 32'(if0.done), 32'd0);
        chk("rst_ready", 32'(if0.ready), 32'd0);

        // Init frame after reset release
        rst_n = 1'b1;
        do_frame("init", 5, 2, 1'b1, 32'h0800_0001, 1'b1, r1, y1, f1);

        // Single write
        start_req(3, 1'b0, 1, 12'hAAA);
        do_frame("wr_ch3", 5, 2, 1'b0, ref_frame(12, 3, 1'b0, 1, 12'hAAA), 1'b0, r1, y1, f1);
        chk("wr_ch3_plan_frame", ref_frame(12, 3, 1'b0, 1, 12'hAAA), 32'h033A_AA00);

        // Back-to-back with st_wrt held high
        start_req(0, 1'b0, 1, 12'b1010_1010_1010);
        do_frame("b2b_1", 5, 2, 1'b1, 32'h030A_AA00, 1'b0, r1, y1, f1);
        do_frame("b2b_2", 5, 2, 1'b1, 32'h030A_AA00, 1'b0, r2, y2, f2);
        chk("b2b_gap12", 32'((y1 - r1) + f2), 32'd3);
        do_frame("b2b_3", 5, 2, 1'b0, 32'h030A_AA00, 1'b0, r3, y3, f3);
        chk("b2b_gap23", 32'((y2 - r2) + f3), 32'd3);

        // Broadcast, write and update all
        start_req(int'($urandom_range(0, 7)), 1'b1, 2, 12'h800);
        do_frame("bcast", 5, 2, 1'b0, 32'h02F8_0000, 1'b0, r1, y1, f1);

        // Random writes
        for (int i = 0; i < 12; i++) begin
            ch = int'($urandom_range(0, 7)); all = int'($urandom_range(0, 1));
            md = int'($urandom_range(0, 3)); dat = int'($urandom_range(0, 4095));
            if ($urandom_range(0, 2) == 0) repeat (int'($urandom_range(1, 4))) @(negedge clk);
            start_req(ch, 1'(all), md, dat);
            do_frame($sformatf("rnd%0d", i), 5, 2, 1'b0, ref_frame(12, ch, 1'(all), md, dat), 1'b0,
                     r1, y1, f1);
        end

        // 16-bit instance, CLK_DIV=2
        sel = 1'b1;
        wait_ready();
        start_req(5, 1'b0, 1, 16'hABCD);
        do_frame("w16", 2, 2, 1'b0, 32'h035A_BCD0, 1'b0, r1, y1, f1);
        chk("w16_ready_cycle", 32'(y1), 32'd131);

        // Out-of-range channel on the 6-channel instance: no frame, one done
        start_req(7, 1'b0, 1, int'($urandom_range(0, 65535)));
        observe(2, 2, 1'b0, fr, nf, xf0, xf1, xcf, xcr, xrc, xdc, xbt);
        $display("badch: falls=%0d cs_low@%0d ready@%0d dones=%0d", nf, xcf, xrc, xdc);
        chk("badch_cs_never_low", 32'(xcf), 32'hFFFF_FFFF);
        chk("badch_falls", 32'(nf), 32'd0);
        chk("badch_done_count", 32'(xdc), 32'd1);
        chk("badch_ready_back", 32'(xrc > 0 && xrc <= 4), 32'd1);

        // Reset mid-frame after the 10th falling sclk edge
        sel = 1'b0;
        wait_ready();
        start_req(2, 1'b0, 1, int'($urandom_range(0, 4095)));
        nf = 0; sp = m_sclk;
        for (int c = 1; c < 400; c++) begin
            @(negedge clk);
            if (c == 1) if0.st_wrt = 1'b0;
            if (sp && !m_sclk) nf++;
            sp = m_sclk;
            if (nf == 10) break;
        end
        chk("midrst_reached_10_falls", 32'(nf), 32'd10);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        $display("midrst: cs=%0b sclk=%0b done=%0b ready=%0b", cs0, sclk0, if0.done, if0.ready);
        chk("midrst_cs", 32'(cs0), 32'd1);
        chk("midrst_sclk", 32'(sclk0), 32'd1);
        chk("midrst_done", 32'(if0.done), 32'd0);
        chk("midrst_ready", 32'(if0.ready), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_frame("reinit", 5, 2, 1'b1, 32'h0800_0001, 1'b1, r1, y1, f1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
